// File: rtl/rtos_ctx_mem_bridge.sv
// Bridges RTOS context store/load requests and a core OBI port onto one OBI memory master.
// Owner tags follow each granted request in order so responses return to the right requester.
module rtos_ctx_mem_bridge #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RDY_mem_wr,
    input  logic [63:0] mem_wr,
    output logic        EN_mem_wr,
    input  logic        RDY_mem_rd_addr,
    input  logic [31:0] mem_rd_addr,
    output logic        EN_mem_rd_addr,
    input  logic        RDY_mem_rd_data,
    output logic        EN_mem_rd_data,
    output logic [31:0] mem_rd_data_d,
    input  logic        core_req_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        proto_err_o
);
    typedef enum logic [1:0] {OWN_CORE = 2'd0, OWN_UWR = 2'd1, OWN_URD = 2'd2} owner_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    state_e           state_q, state_d;
    owner_e           lock_owner_q, lock_owner_d;
    owner_e           tag_q [MAX_OUTSTANDING];
    owner_e           tag_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             urd_pend_q, urd_pend_d;
    logic             buf_full_q, buf_full_d;
    logic [31:0]      buf_data_q, buf_data_d;
    logic             proto_err_q, proto_err_d;

    logic   arb_valid, req_act, grant, pop;
    owner_e arb_owner, sel_owner, head_tag;
    logic   unused_bits;

    assign unused_bits = ^{mem_wr[63:62], mem_rd_addr[31:30]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Fixed priority; a load waits until the previous load has fully drained.
    always_comb begin
        arb_valid = 1'b0;
        arb_owner = OWN_CORE;
        if (RDY_mem_wr) begin
            arb_valid = 1'b1;
            arb_owner = OWN_UWR;
        end else if (RDY_mem_rd_addr && !buf_full_q && !urd_pend_q) begin
            arb_valid = 1'b1;
            arb_owner = OWN_URD;
        end else if (core_req_i) begin
            arb_valid = 1'b1;
            arb_owner = OWN_CORE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            lock_owner_q <= OWN_CORE;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    // Once a request is on the bus the owner is frozen until the grant arrives.
    always_comb begin
        req_act      = !rst_i && ((state_q == ST_LOCKED) || (arb_valid && (cnt_q < MAX_CNT)));
        sel_owner    = (state_q == ST_LOCKED) ? lock_owner_q : arb_owner;
        grant        = req_act && data_gnt_i;
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        case (state_q)
            ST_IDLE: begin
                lock_owner_d = arb_owner;
                if (req_act && !data_gnt_i) state_d = ST_LOCKED;
            end
            ST_LOCKED: if (data_gnt_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_req_o     = req_act;
        EN_mem_wr      = grant && (sel_owner == OWN_UWR);
        EN_mem_rd_addr = grant && (sel_owner == OWN_URD);
        core_gnt_o     = grant && (sel_owner == OWN_CORE);
        data_we_o      = core_we_i;
        data_be_o      = core_be_i;
        data_addr_o    = core_addr_i;
        data_wdata_o   = core_wdata_i;
        case (sel_owner)
            OWN_UWR: begin
                data_we_o    = 1'b1;
                data_be_o    = 4'hF;
                data_addr_o  = {mem_wr[61:32], 2'b00};
                data_wdata_o = mem_wr[31:0];
            end
            OWN_URD: begin
                data_we_o    = 1'b0;
                data_be_o    = 4'hF;
                data_addr_o  = {mem_rd_addr[29:0], 2'b00};
                data_wdata_o = 32'h0;
            end
            default: ;
        endcase
    end

    // A response with no tag in flight is a protocol violation and is dropped.
    always_comb begin
        head_tag       = tag_q[rd_ptr_q];
        pop            = !rst_i && data_rvalid_i && (cnt_q != 3'd0);
        core_rvalid_o  = pop && (head_tag == OWN_CORE);
        core_rdata_o   = data_rdata_i;
        EN_mem_rd_data = !rst_i && buf_full_q && RDY_mem_rd_data;
        mem_rd_data_d  = buf_data_q;
        proto_err_o    = proto_err_q;

        tag_d      = tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q + {2'b00, grant} - {2'b00, pop};
        urd_pend_d = urd_pend_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        proto_err_d = proto_err_q | (data_rvalid_i && (cnt_q == 3'd0));

        if (grant) begin
            tag_d[wr_ptr_q] = sel_owner;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            if (sel_owner == OWN_URD) urd_pend_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (head_tag == OWN_URD) begin
                urd_pend_d = 1'b0;
                buf_full_d = 1'b1;
                buf_data_d = data_rdata_i;
            end
        end
        if (EN_mem_rd_data) buf_full_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= OWN_CORE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= 3'd0;
            urd_pend_q  <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_data_q  <= 32'h0;
            proto_err_q <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            urd_pend_q  <= urd_pend_d;
            buf_full_q  <= buf_full_d;
            buf_data_q  <= buf_data_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_rtos_ctx_mem_bridge.sv
// Bench for rtos_ctx_mem_bridge: directed scenarios, then random traffic against a
// word-addressed memory model whose read data is a fixed function of the address.
module tb_rtos_ctx_mem_bridge;
    localparam int MAX_OUT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RDY_mem_wr, EN_mem_wr, RDY_mem_rd_addr, EN_mem_rd_addr;
    logic [63:0] mem_wr;
    logic [31:0] mem_rd_addr, mem_rd_data_d;
    logic        RDY_mem_rd_data, EN_mem_rd_data;
    logic        core_req_i, core_gnt_o, core_rvalid_o, core_we_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic        proto_err_o;

    rtos_ctx_mem_bridge #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RDY_mem_wr(RDY_mem_wr), .mem_wr(mem_wr), .EN_mem_wr(EN_mem_wr),
        .RDY_mem_rd_addr(RDY_mem_rd_addr), .mem_rd_addr(mem_rd_addr), .EN_mem_rd_addr(EN_mem_rd_addr),
        .RDY_mem_rd_data(RDY_mem_rd_data), .EN_mem_rd_data(EN_mem_rd_data), .mem_rd_data_d(mem_rd_data_d),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_we_i(core_we_i), .core_be_i(core_be_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard state
    logic [63:0] store_exp_q[$];
    logic [31:0] load_addr_exp_q[$];
    logic [31:0] load_data_exp_q[$];
    logic [32:0] core_exp_q[$];
    logic [32:0] mem_q[$];
    bit          mon_en = 1'b0;
    bit          hs_wr = 1'b0, hs_core = 1'b0;
    int          out_cnt = 0;
    int          loads_inflight = 0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0;
    logic [63:0] prev_ab;
    logic [4:0]  prev_wb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic idle();
        RDY_mem_wr = 1'b0; mem_wr = 64'h0; RDY_mem_rd_addr = 1'b0; mem_rd_addr = 32'h0;
        RDY_mem_rd_data = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_be_i = 4'h0;
        core_addr_i = 32'h0; core_wdata_i = 32'h0; data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        idle();
        tick(); tick();
        rst_i = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake or response.
    always @(negedge clk_i) begin
        if (mon_en) begin
            logic        grant;
            int          pre;
            logic [32:0] e33;
            hs_wr   = EN_mem_wr;
            hs_core = core_gnt_o;
            grant   = data_req_o && data_gnt_i;
            if (out_cnt == MAX_OUT) chk("limit_hold", data_req_o, 0);
            if (prev_req && !prev_gnt) begin
                chk("lock_req", data_req_o, 1);
                chk("lock_addr_data", {data_addr_o, data_wdata_o}, prev_ab);
                chk("lock_we_be", {data_we_o, data_be_o}, prev_wb);
            end
            chk("owner_onehot", int'(EN_mem_wr) + int'(EN_mem_rd_addr) + int'(core_gnt_o), grant);
            if (grant) mem_q.push_back({data_we_o, data_addr_o});
            if (EN_mem_wr) begin
                chk("store_pending", store_exp_q.size() > 0, 1);
                if (store_exp_q.size() > 0) chk("store_bus", {data_addr_o, data_wdata_o}, store_exp_q.pop_front());
                chk("store_we_be", {data_we_o, data_be_o}, 5'h1F);
            end
            if (EN_mem_rd_addr) begin
                chk("load_gate", loads_inflight, 0);
                chk("load_pending", load_addr_exp_q.size() > 0, 1);
                if (load_addr_exp_q.size() > 0)
                    chk("load_bus", {data_we_o, data_be_o, data_addr_o}, {1'b0, 4'hF, load_addr_exp_q.pop_front()});
                loads_inflight++;
            end
            if (core_gnt_o) begin
                chk("core_addr", data_addr_o, core_addr_i);
                chk("core_we_be", {data_we_o, data_be_o}, {core_we_i, core_be_i});
                if (core_we_i) chk("core_wdata", data_wdata_o, core_wdata_i);
            end
            if (core_rvalid_o) begin
                chk("core_rsp_pending", core_exp_q.size() > 0, 1);
                if (core_exp_q.size() > 0) begin
                    e33 = core_exp_q.pop_front();
                    if (!e33[32]) chk("core_rdata", core_rdata_o, e33[31:0]);
                end
            end
            if (EN_mem_rd_data) begin
                chk("rd_data_ready", RDY_mem_rd_data, 1);
                chk("rd_data_pending", load_data_exp_q.size() > 0, 1);
                if (load_data_exp_q.size() > 0) chk("rd_data", mem_rd_data_d, load_data_exp_q.pop_front());
                loads_inflight--;
            end
            chk("proto_err_quiet", proto_err_o, 0);
            pre = out_cnt;
            out_cnt = pre + int'(grant) - ((data_rvalid_i && pre > 0) ? 1 : 0);
            prev_req = data_req_o;
            prev_gnt = data_gnt_i;
            prev_ab  = {data_addr_o, data_wdata_o};
            prev_wb  = {data_we_o, data_be_o};
        end
    end

    initial begin
        int  st_left, ld_left, co_left;
        bit  done;
        logic [31:0] a, d;
        logic [32:0] e;

        // Reset holds every handshake output low even with all requests asserted
        rst_i = 1'b1;
        idle();
        RDY_mem_wr = 1'b1; core_req_i = 1'b1; data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
        smp();
        chk("rst_req", data_req_o, 0);
        chk("rst_en_wr", EN_mem_wr, 0);
        chk("rst_core_gnt", core_gnt_o, 0);
        chk("rst_core_rvalid", core_rvalid_o, 0);
        tick(); idle(); tick();
        rst_i = 1'b0;
        smp();
        chk("rst_proto_err", proto_err_o, 0);
        chk("rst_rd_data", EN_mem_rd_data, 0);
        chk("rst_idle_req", data_req_o, 0);

        // Single store
        tick();
        RDY_mem_wr = 1'b1; mem_wr = {32'h40, 32'hDEADBEEF}; data_gnt_i = 1'b1;
        smp();
        chk("st_req", data_req_o, 1);
        chk("st_addr", data_addr_o, 32'h100);
        chk("st_wdata", data_wdata_o, 32'hDEADBEEF);
        chk("st_we_be", {data_we_o, data_be_o}, 5'h1F);
        chk("st_en", EN_mem_wr, 1);
        tick(); idle();
        smp();
        chk("st_en_pulse", EN_mem_wr, 0);
        tick(); data_rvalid_i = 1'b1; data_rdata_i = 32'h55; RDY_mem_rd_data = 1'b1;
        smp();
        chk("st_rsp_core", core_rvalid_o, 0);
        tick(); idle(); RDY_mem_rd_data = 1'b1;
        smp();
        chk("st_rsp_unit", EN_mem_rd_data, 0);
        chk("st_no_proto", proto_err_o, 0);

        // Load path with a stalled consumer and a second load waiting
        tick(); idle();
        RDY_mem_rd_addr = 1'b1; mem_rd_addr = 32'h41; data_gnt_i = 1'b1;
        smp();
        chk("ld_en", EN_mem_rd_addr, 1);
        chk("ld_addr", data_addr_o, 32'h104);
        chk("ld_we_be", {data_we_o, data_be_o}, 5'h0F);
        tick(); mem_rd_addr = 32'h50;
        smp();
        chk("ld_block_pend", data_req_o, 0);
        tick(); data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
        smp();
        chk("ld_block_rsp", data_req_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); data_rvalid_i = 1'b0;
            smp();
            chk("ld_hold_data", EN_mem_rd_data, 0);
            chk("ld_block_buf", data_req_o, 0);
        end
        tick(); RDY_mem_rd_data = 1'b1;
        smp();
        chk("ld_deliver", EN_mem_rd_data, 1);
        chk("ld_data", mem_rd_data_d, 32'h12345678);
        tick(); RDY_mem_rd_data = 1'b0;
        smp();
        chk("ld_once", EN_mem_rd_data, 0);
        chk("ld2_en", EN_mem_rd_addr, 1);
        chk("ld2_addr", data_addr_o, 32'h140);
        tick(); RDY_mem_rd_addr = 1'b0; data_gnt_i = 1'b0;
        tick(); data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
        tick(); data_rvalid_i = 1'b0; RDY_mem_rd_data = 1'b1;
        smp();
        chk("ld2_data", {31'h0, EN_mem_rd_data, mem_rd_data_d}, {32'h1, 32'hCAFEF00D});
        tick(); idle();

        // Store beats core when both arrive together; responses route by tag
        core_req_i = 1'b1; core_addr_i = 32'h3000; core_we_i = 1'b0; core_be_i = 4'h3;
        RDY_mem_wr = 1'b1; mem_wr = {32'h10, 32'h1111}; data_gnt_i = 1'b1;
        smp();
        chk("arb_core_wait", core_gnt_o, 0);
        chk("arb_store_first", {EN_mem_wr, data_addr_o}, {1'b1, 32'h40});
        tick(); RDY_mem_wr = 1'b0;
        smp();
        chk("arb_core_gnt", core_gnt_o, 1);
        chk("arb_core_bus", {data_we_o, data_be_o, data_addr_o}, {1'b0, 4'h3, 32'h3000});
        tick(); core_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h77;
        smp();
        chk("tag_uwr", core_rvalid_o, 0);
        tick(); data_rdata_i = 32'h88;
        smp();
        chk("tag_core", {31'h0, core_rvalid_o, core_rdata_o}, {32'h1, 32'h88});
        tick(); idle();

        // Lock: core request held ungranted while a store arrives
        core_req_i = 1'b1; core_addr_i = 32'h2000; core_we_i = 1'b1; core_be_i = 4'hF;
        core_wdata_i = 32'hAAAA5555;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("lock_hold_req", data_req_o, 1);
            chk("lock_hold_bus", {data_addr_o, data_wdata_o}, {32'h2000, 32'hAAAA5555});
            tick();
            if (i == 1) begin
                RDY_mem_wr = 1'b1; mem_wr = {32'h20, 32'hBBBB0000};
            end
        end
        data_gnt_i = 1'b1;
        smp();
        chk("lock_core_gnt", {core_gnt_o, EN_mem_wr, data_addr_o}, {2'b10, 32'h2000});
        tick(); core_req_i = 1'b0;
        smp();
        chk("lock_unit_after", {EN_mem_wr, data_addr_o}, {1'b1, 32'h80});
        tick(); RDY_mem_wr = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        smp();
        chk("lock_rsp_core", core_rvalid_o, 1);
        tick();
        smp();
        chk("lock_rsp_unit", core_rvalid_o, 0);
        tick(); idle();

        // Outstanding limit
        core_req_i = 1'b1; core_addr_i = 32'h400; core_be_i = 4'hF; data_gnt_i = 1'b1;
        smp(); chk("lim_g1", core_gnt_o, 1);
        tick(); core_addr_i = 32'h404;
        smp(); chk("lim_g2", core_gnt_o, 1);
        tick(); core_addr_i = 32'h408;
        smp(); chk("lim_full", {data_req_o, core_gnt_o}, 2'b00);
        tick(); data_rvalid_i = 1'b1; data_rdata_i = 32'h1;
        smp();
        chk("lim_same_cycle", data_req_o, 0);
        chk("lim_rsp", core_rvalid_o, 1);
        tick(); data_rvalid_i = 1'b0;
        smp(); chk("lim_reissue", {data_req_o, core_gnt_o, data_addr_o}, {2'b11, 32'h408});
        tick(); core_req_i = 1'b0; data_gnt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_rvalid_i = 1'b1;
            smp(); chk("lim_drain", core_rvalid_o, 1);
            tick();
        end
        idle();

        // Reset with two outstanding, then a stray response
        core_req_i = 1'b1; core_addr_i = 32'h500; data_gnt_i = 1'b1;
        tick(); tick();
        idle(); rst_i = 1'b1;
        tick(); rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h99;
        smp(); chk("rst_drop_rvalid", core_rvalid_o, 0);
        tick(); data_rvalid_i = 1'b0;
        smp(); chk("proto_set", proto_err_o, 1);
        tick(); tick();
        smp(); chk("proto_sticky", proto_err_o, 1);
        rst_i = 1'b1;
        tick(); rst_i = 1'b0;
        smp(); chk("proto_cleared", proto_err_o, 0);

        // Random traffic
        reset_dut();
        out_cnt = 0; loads_inflight = 0; prev_req = 1'b0; prev_gnt = 1'b0;
        mon_en = 1'b1;
        st_left = 40; ld_left = 30; co_left = 60;
        done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            tick();
            if (RDY_mem_wr && hs_wr) RDY_mem_wr = 1'b0;
            if (!RDY_mem_wr && st_left > 0 && $urandom_range(0, 3) == 0) begin
                a = $urandom; d = $urandom;
                mem_wr = {a, d}; RDY_mem_wr = 1'b1;
                store_exp_q.push_back({a[29:0], 2'b00, d});
                st_left--;
            end
            if (RDY_mem_rd_addr && EN_mem_rd_addr === 1'b0 && load_addr_exp_q.size() == 0) RDY_mem_rd_addr = 1'b0;
            if (!RDY_mem_rd_addr && ld_left > 0 && $urandom_range(0, 3) == 0) begin
                a = $urandom;
                mem_rd_addr = a; RDY_mem_rd_addr = 1'b1;
                load_addr_exp_q.push_back({a[29:0], 2'b00});
                load_data_exp_q.push_back(mem_f({a[29:0], 2'b00}));
                ld_left--;
            end
            if (core_req_i && hs_core) core_req_i = 1'b0;
            if (!core_req_i && co_left > 0 && $urandom_range(0, 2) == 0) begin
                core_addr_i = $urandom; core_we_i = 1'($urandom_range(0, 1));
                core_be_i = 4'($urandom); core_wdata_i = $urandom;
                core_exp_q.push_back({core_we_i, mem_f(core_addr_i)});
                core_req_i = 1'b1;
                co_left--;
            end
            RDY_mem_rd_data = 1'($urandom_range(0, 1));
            data_gnt_i = ($urandom_range(0, 2) != 0);
            if (mem_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                e = mem_q.pop_front();
                data_rvalid_i = 1'b1;
                data_rdata_i = e[32] ? $urandom : mem_f(e[31:0]);
            end else begin
                data_rvalid_i = 1'b0;
                data_rdata_i = $urandom;
            end
            done = (st_left == 0) && (ld_left == 0) && (co_left == 0) && !RDY_mem_wr &&
                   !RDY_mem_rd_addr && !core_req_i && (store_exp_q.size() == 0) &&
                   (load_data_exp_q.size() == 0) && (core_exp_q.size() == 0) && (mem_q.size() == 0);
        end
        smp();
        tick(); idle();
        smp();
        mon_en = 1'b0;
        chk("drain_done", done, 1);
        chk("drain_outstanding", out_cnt, 0);
        chk("drain_loads", loads_inflight, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rtos_ctx_mem_bridge.md
RTOS_CTX_MEM_BRIDGE -- requirements
Module: rtos_ctx_mem_bridge

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted transactions awaiting rvalid (legal values 1..4).
REQ-002 SHALL have one clock and a synchronous active-high reset, listed first:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
REQ-003 SHALL have these RTOS unit ports:
- RDY_mem_wr  in  1  unit has a context store pending
- mem_wr  in  64  store request; [63:32] word address, [31:0] data
- EN_mem_wr  out  1  dequeue-pulse for the store request
- RDY_mem_rd_addr  in  1  unit has a context load pending
- mem_rd_addr  in  32  load word address
- EN_mem_rd_addr  out  1  dequeue-pulse for the load request
- RDY_mem_rd_data  in  1  unit can accept load data
- EN_mem_rd_data  out  1  load data valid
- mem_rd_data_d  out  32  load data
REQ-004 SHALL have these core OBI slave ports:
- core_req_i  in  1
- core_gnt_o  out  1
- core_rvalid_o  out  1
- core_we_i  in  1
- core_be_i  in  4
- core_addr_i  in  32
- core_wdata_i  in  32
- core_rdata_o  out  32
REQ-005 SHALL have these memory OBI master ports:
- data_req_o  out  1
- data_gnt_i  in  1
- data_rvalid_i  in  1
- data_we_o  out  1
- data_be_o  out  4
- data_addr_o  out  32
- data_wdata_o  out  32
- data_rdata_i  in  32
REQ-006 SHALL have output proto_err_o (1 bit), a sticky flag set on rvalid with nothing outstanding.

Function
REQ-007 SHALL drive all unit store/load transactions with data_be_o=4'hF and data_addr_o={address[29:0],2'b00}.
REQ-008 SHALL arbitrate with fixed priority: unit store > unit load > core.
REQ-009 SHALL permit a unit load only when the read-data buffer is empty and no unit load is outstanding.
REQ-010 SHALL lock the selected requester once data_req_o rises; data_req_o, we, be, addr and wdata stay stable until data_gnt_i, with no re-arbitration.
REQ-011 SHALL issue no new request while the outstanding count equals MAX_OUTSTANDING; a same-cycle rvalid does not free a slot until the next cycle.
REQ-012 SHALL pulse EN_mem_wr or EN_mem_rd_addr in exactly the cycle data_req_o&data_gnt_i completes the corresponding unit request.
REQ-013 SHALL set core_gnt_o=data_gnt_i only while the core owns the request; otherwise core_gnt_o=0.
REQ-014 SHALL push the owner tag {CORE, UWR, URD} into an in-order FIFO of depth MAX_OUTSTANDING on each grant.
REQ-015 SHALL pop the owner FIFO on each data_rvalid_i and route the response by tag:
- CORE: core_rvalid_o=1 and core_rdata_o=data_rdata_i in the same cycle (combinational).
- UWR: response discarded.
- URD: data_rdata_i captured into the one-entry read-data buffer.
REQ-016 SHALL hold EN_mem_rd_data=1 with mem_rd_data_d=buffer whenever the buffer is full and RDY_mem_rd_data=1; the buffer empties that cycle. Minimum latency from rvalid to EN_mem_rd_data is 1 cycle.
REQ-017 SHALL handle a simultaneous grant and rvalid in one cycle as push plus pop, leaving the count unchanged.
REQ-018 SHALL, on rvalid with an empty owner FIFO, ignore the data and set proto_err_o.

Reset
REQ-019 SHALL, while rst_i=1 at a clock edge, reset all of the following to 0: data_req_o, EN_mem_wr, EN_mem_rd_addr, EN_mem_rd_data, core_gnt_o, core_rvalid_o, proto_err_o, the outstanding count, the owner FIFO, the buffer-full flag and the request lock.
REQ-020 SHALL reset mid-transaction by dropping all outstanding state; later rvalids set proto_err_o per REQ-018.

Verification
REQ-021 Single store: RDY_mem_wr=1, mem_wr={32'h40,32'hDEADBEEF}, gnt the same cycle -> data_addr_o=32'h100, data_wdata_o=32'hDEADBEEF, we=1, EN_mem_wr pulses 1 cycle, later rvalid not forwarded anywhere.
REQ-022 Load path: mem_rd_addr=32'h41, gnt the same cycle, rvalid 2 cycles later with rdata=32'h12345678, RDY_mem_rd_data held 0 for 3 cycles -> EN_mem_rd_data=1 with 32'h12345678 only when RDY rises; no second load issued meanwhile.
REQ-023 Contention: core_req_i and RDY_mem_wr both rise in cycle 0 -> unit store granted first, core_gnt_o=0 until the store's grant cycle passes; the core then gets the grant.
REQ-024 Lock: core request raised, data_gnt_i held 0 for 4 cycles, then RDY_mem_wr=1 -> address and data stay at the core's values until the grant; unit served afterwards.
REQ-025 Limit: MAX_OUTSTANDING=2, two core reads granted, no rvalid -> data_req_o=0 on the third request; one rvalid -> request reissued the following cycle; rvalid order maps to core, then unit, per tags.
REQ-026 Reset with 2 outstanding, then 1 rvalid -> core_rvalid_o=0, proto_err_o=1 until the next reset.
